// File: rtl/fifo_north_pkg.sv
// Shared types and helpers for the north-edge skewed FIFO bank.
package fifo_north_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} drain_state_t;

  // Column 0 occupies the most significant slice of a packed bus.
  function automatic int unsigned col_slice(int unsigned i, int unsigned col,
                                            int unsigned w_data);
    return w_data * (col - 1 - i);
  endfunction

endpackage

// File: rtl/fifo_north_chan.sv
// One column FIFO: storage, pointers, occupancy count and registered read data/valid.
module fifo_north_chan #(
  parameter int unsigned W_DATA = 8,
  parameter int unsigned W_ADDR = 4
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_wr_en,
  input  logic [W_DATA-1:0] i_wr_data,
  input  logic              i_rd_req,
  output logic [W_DATA-1:0] o_data,
  output logic              o_dv,
  output logic              o_empty,
  output logic              o_full
);

  localparam int unsigned DEPTH = 1 << W_ADDR;
  localparam int unsigned W_CNT = W_ADDR + 1;

  logic [W_DATA-1:0] mem_q [DEPTH];
  logic [W_ADDR-1:0] wr_ptr_q, wr_ptr_d;
  logic [W_ADDR-1:0] rd_ptr_q, rd_ptr_d;
  logic [W_CNT-1:0]  count_q, count_d;
  logic [W_DATA-1:0] data_q, data_d;
  logic              dv_q, dv_d;
  logic              rd_ok, wr_ok;

  assign o_empty = (count_q == '0);
  assign o_full  = (count_q == W_CNT'(DEPTH));
  assign rd_ok   = i_rd_req && !o_empty;
  // A full column still accepts a write when a read frees a slot in the same cycle.
  assign wr_ok   = i_wr_en && (!o_full || rd_ok);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    data_d   = '0;
    dv_d     = rd_ok;
    if (wr_ok) wr_ptr_d = wr_ptr_q + W_ADDR'(1);
    if (rd_ok) begin
      rd_ptr_d = rd_ptr_q + W_ADDR'(1);
      data_d   = mem_q[rd_ptr_q];
    end
    unique case ({wr_ok, rd_ok})
      2'b10:   count_d = count_q + W_CNT'(1);
      2'b01:   count_d = count_q - W_CNT'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (wr_ok) mem_q[wr_ptr_q] <= i_wr_data;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      data_q   <= '0;
      dv_q     <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      data_q   <= data_d;
      dv_q     <= dv_d;
    end
  end

  assign o_data = data_q;
  assign o_dv   = dv_q;

endmodule

// File: rtl/fifo_north_skew.sv
// Bank of COL column FIFOs with a diagonal-wavefront drain controller.
// Optional sticky error flags: define FIFO_NORTH_SKEW_ERR_EN.
module fifo_north_skew
  import fifo_north_pkg::*;
#(
  parameter int unsigned COL    = 3,
  parameter int unsigned W_DATA = 8,
  parameter int unsigned W_ADDR = 4,
  parameter int unsigned W_LEN  = W_ADDR + 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [COL-1:0]        i_wr_en,
  input  logic [COL*W_DATA-1:0] i_wr_data,
  input  logic [COL-1:0]        i_rd_en,
  input  logic                  i_start,
  input  logic [W_LEN-1:0]      i_len,
  input  logic                  i_hold,
  output logic [COL*W_DATA-1:0] o_data,
  output logic [COL-1:0]        o_dv,
  output logic [COL-1:0]        o_empty,
  output logic [COL-1:0]        o_full,
  output logic                  o_busy,
  output logic                  o_done
`ifdef FIFO_NORTH_SKEW_ERR_EN
  ,
  output logic [COL-1:0]        o_overflow,
  output logic [COL-1:0]        o_underflow
`endif
);

  // Wide enough for len + COL without wrapping.
  localparam int unsigned W_T = W_LEN + $clog2(COL) + 1;

  drain_state_t     state_q, state_d;
  logic [W_T-1:0]   t_q, t_d;
  logic [W_LEN-1:0] len_q, len_d;
  logic [COL-1:0]   rd_req;

  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    len_d   = len_q;
    rd_req  = '0;
    o_done  = 1'b0;
    unique case (state_q)
      IDLE: begin
        rd_req = i_rd_en;
        if (i_start) begin
          len_d   = i_len;
          t_d     = '0;
          state_d = (i_len == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (!i_hold) begin
          // Column i owns slots t = i .. i+len-1.
          for (int i = 0; i < int'(COL); i++) begin
            rd_req[i] = (t_q >= W_T'(i)) && (t_q < W_T'(i) + W_T'(len_q));
          end
          t_d = t_q + W_T'(1);
          if (t_q + W_T'(2) == W_T'(len_q) + W_T'(COL)) state_d = DONE;
        end
      end
      DONE: begin
        o_done  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      t_q     <= '0;
      len_q   <= '0;
    end else begin
      state_q <= state_d;
      t_q     <= t_d;
      len_q   <= len_d;
    end
  end

  assign o_busy = (state_q != IDLE);

  for (genvar g = 0; g < COL; g++) begin : g_chan
    localparam int unsigned Base = col_slice(g, COL, W_DATA);
    fifo_north_chan #(
      .W_DATA (W_DATA),
      .W_ADDR (W_ADDR)
    ) u_chan (
      .i_clk     (i_clk),
      .i_rst_n   (i_rst_n),
      .i_wr_en   (i_wr_en[g]),
      .i_wr_data (i_wr_data[Base +: W_DATA]),
      .i_rd_req  (rd_req[g]),
      .o_data    (o_data[Base +: W_DATA]),
      .o_dv      (o_dv[g]),
      .o_empty   (o_empty[g]),
      .o_full    (o_full[g])
    );
  end

`ifdef FIFO_NORTH_SKEW_ERR_EN
  logic [COL-1:0] ovf_q, ovf_d, unf_q, unf_d;

  always_comb begin
    ovf_d = ovf_q;
    unf_d = unf_q;
    for (int i = 0; i < int'(COL); i++) begin
      if (i_wr_en[i] && o_full[i] && !(rd_req[i] && !o_empty[i])) ovf_d[i] = 1'b1;
      if ((state_q == RUN) && rd_req[i] && o_empty[i]) unf_d[i] = 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      ovf_q <= '0;
      unf_q <= '0;
    end else begin
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  assign o_overflow  = ovf_q;
  assign o_underflow = unf_q;
`endif

endmodule

// File: tb/tb_fifo_north_skew.sv
// Scoreboard bench for fifo_north_skew: writes queue expected words, a monitor checks reads.
module tb_fifo_north_skew;

  logic        clk;
  logic        rst_n;
  logic [2:0]  wr_en;
  logic [23:0] wr_data;
  logic [2:0]  rd_en;
  logic        start;
  logic [4:0]  len_i;
  logic        hold;
  logic [23:0] data_o;
  logic [2:0]  dv;
  logic [2:0]  empty;
  logic [2:0]  full;
  logic        busy;
  logic        done;

  int total = 0;
  int bad   = 0;
  logic mon_en = 1'b0;

  logic [7:0] q0[$];
  logic [7:0] q1[$];
  logic [7:0] q2[$];

  fifo_north_skew dut (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .i_wr_en   (wr_en),
    .i_wr_data (wr_data),
    .i_rd_en   (rd_en),
    .i_start   (start),
    .i_len     (len_i),
    .i_hold    (hold),
    .o_data    (data_o),
    .o_dv      (dv),
    .o_empty   (empty),
    .o_full    (full),
    .o_busy    (busy),
    .o_done    (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  task automatic push(input int c, input logic [7:0] v);
    case (c)
      0: q0.push_back(v);
      1: q1.push_back(v);
      default: q2.push_back(v);
    endcase
  endtask

  function automatic int qsize(input int c);
    case (c)
      0: return q0.size();
      1: return q1.size();
      default: return q2.size();
    endcase
  endfunction

  task automatic pop(input int c, output logic [7:0] v);
    case (c)
      0: v = q0.pop_front();
      1: v = q1.pop_front();
      default: v = q2.pop_front();
    endcase
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_wd(input int c, input logic [7:0] v);
    wr_data[8*(3-c)-1 -: 8] = v;
  endtask

  // Monitor: every column, every cycle.
  always @(negedge clk) begin
    logic [7:0] got;
    logic [7:0] ev;
    if (mon_en) begin
      for (int i = 0; i < 3; i++) begin
        got = data_o[8*(3-i)-1 -: 8];
        total++;
        if (dv[i]) begin
          if (qsize(i) == 0) begin
            bad++;
            $display("FAIL sb_extra col%0d act=%0h exp=none", i, got);
          end else begin
            pop(i, ev);
            if (got !== ev) begin
              bad++;
              $display("FAIL sb_data col%0d act=%0h exp=%0h", i, got, ev);
            end
          end
        end else if (got !== 8'h00) begin
          bad++;
          $display("FAIL idle_data col%0d act=%0h exp=0", i, got);
        end
      end
    end
  end

  task automatic preload(input logic [7:0] base);
    for (int k = 0; k < 4; k++) begin
      wr_en = 3'b111;
      for (int c = 0; c < 3; c++) begin
        set_wd(c, base + 8'(16 * c + k));
        push(c, base + 8'(16 * c + k));
      end
      tick();
    end
    wr_en = 3'b000;
  endtask

  // Cycle k=0 is the cycle start is high; masks give expected dv/done per cycle.
  task automatic run_drain(input logic [4:0] len, input int hs, input int hn,
                           input logic [15:0] m0, input logic [15:0] m1,
                           input logic [15:0] m2, input int donec, input int ncyc);
    len_i = len;
    start = 1'b1;
    for (int k = 0; k < ncyc; k++) begin
      if (k > 0) begin
        tick();
        start = 1'b0;
        hold  = (k >= hs) && (k < hs + hn);
      end
      @(negedge clk);
      chk($sformatf("dv0_k%0d", k), dv[0], m0[k]);
      chk($sformatf("dv1_k%0d", k), dv[1], m1[k]);
      chk($sformatf("dv2_k%0d", k), dv[2], m2[k]);
      chk($sformatf("done_k%0d", k), done, (k == donec));
      chk($sformatf("busy_k%0d", k), busy, (k >= 1) && (k <= donec));
    end
    tick();
    start = 1'b0;
    hold  = 1'b0;
  endtask

  initial begin
    rst_n   = 1'b0;
    wr_en   = '0;
    wr_data = '0;
    rd_en   = '0;
    start   = 1'b0;
    len_i   = '0;
    hold    = 1'b0;

    // Reset
    repeat (2) tick();
    @(negedge clk);
    chk("rst_empty", empty, 3'b111);
    chk("rst_full", full, 3'b000);
    chk("rst_dv", dv, 3'b000);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_data", data_o, 24'h0);
    tick();
    rst_n  = 1'b1;
    mon_en = 1'b1;

    // Fill column 1 past depth; 17th write dropped
    for (int k = 1; k <= 17; k++) begin
      wr_en = 3'b010;
      set_wd(1, 8'(k));
      if (k <= 16) push(1, 8'(k));
      tick();
      if (k == 15) chk("fill_not_full15", full[1], 1'b0);
      if (k == 16) chk("fill_full16", full, 3'b010);
    end
    wr_en = '0;
    chk("fill_full17", full[1], 1'b1);
    rd_en = 3'b010;
    repeat (16) tick();
    rd_en = '0;
    tick();
    chk("drain1_empty", empty, 3'b111);
    rd_en = 3'b010;
    tick();
    rd_en = '0;
    @(negedge clk);
    chk("read_empty_dv", dv, 3'b000);
    tick();

    // Read+write on a full column: both accepted
    for (int k = 0; k < 16; k++) begin
      wr_en = 3'b001;
      set_wd(0, 8'h20 + 8'(k));
      push(0, 8'h20 + 8'(k));
      tick();
    end
    chk("col0_full", full[0], 1'b1);
    wr_en = 3'b001;
    rd_en = 3'b001;
    set_wd(0, 8'h99);
    push(0, 8'h99);
    tick();
    wr_en = '0;
    chk("rw_full_stays_full", full[0], 1'b1);
    repeat (16) tick();
    rd_en = '0;
    tick();
    chk("rw_drained_empty", empty[0], 1'b1);

    // Write into empty column with simultaneous read: read not served
    wr_en = 3'b100;
    rd_en = 3'b100;
    set_wd(2, 8'h55);
    tick();
    wr_en = '0;
    rd_en = '0;
    @(negedge clk);
    chk("nofall_dv2", dv[2], 1'b0);
    chk("nofall_not_empty", empty[2], 1'b0);
    tick();
    push(2, 8'h55);
    rd_en = 3'b100;
    tick();
    rd_en = '0;
    tick();
    chk("nofall_empty_after", empty[2], 1'b1);

    // Skewed drain, len 4
    preload(8'h40);
    run_drain(5'd4, 0, 0, 16'h003C, 16'h0078, 16'h00F0, 7, 10);
    chk("skew_empty", empty, 3'b111);

    // Same drain with a 3-cycle hold
    preload(8'h60);
    run_drain(5'd4, 3, 3, 16'h018C, 16'h0388, 16'h0780, 10, 13);
    chk("hold_empty", empty, 3'b111);

    // len 0: done next cycle, nothing read
    wr_en = 3'b001;
    set_wd(0, 8'hA5);
    tick();
    wr_en = '0;
    run_drain(5'd0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 1, 4);
    chk("len0_kept", empty, 3'b110);
    push(0, 8'hA5);
    rd_en = 3'b001;
    tick();
    rd_en = '0;
    tick();
    chk("len0_flushed", empty, 3'b111);

    // Reset in the middle of RUN
    preload(8'h80);
    len_i = 5'd4;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    rst_n = 1'b0;
    tick();
    q0.delete();
    q1.delete();
    q2.delete();
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_empty", empty, 3'b111);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_dv", dv, 3'b000);
    for (int k = 0; k < 10; k++) begin
      tick();
      @(negedge clk);
      chk($sformatf("midrst_done_k%0d", k), done, 1'b0);
    end
    tick();

    chk("sb_leftover", qsize(0) + qsize(1) + qsize(2), 0);
    mon_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
